// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - streams a burst of ROM words out through a valid/ready port
module rom_streamer #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   reads_left;
  logic              in_flight;
  logic              in_flight_last;

  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_idx;
  logic              rd_idx;
  logic [1:0]        fifo_cnt;

  logic              hs;
  logic              last_hs;
  logic              issue;
  logic [2:0]        demand;

  // Occupancy the FIFO will see once the pending read lands and this cycle's pop retires;
  // a new read is only safe while that stays at most one entry.
  always_comb begin
    hs      = m_valid & m_ready;
    last_hs = hs & fifo_last[rd_idx];
    demand  = {1'b0, fifo_cnt} + {2'b00, in_flight} - {2'b00, hs};
    issue   = (state == RUN) && (reads_left != '0) && (demand <= 3'd1);
  end

  assign rom_en   = issue;
  assign rom_addr = rd_ptr;
  assign m_valid  = (fifo_cnt != 2'd0);
  assign m_data   = fifo_data[rd_idx];
  assign m_last   = m_valid & fifo_last[rd_idx];
  assign busy     = (state != IDLE);

  // Burst control: accept start in IDLE, issue reads in RUN, wait for the final pop in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      reads_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            rd_ptr     <= start_addr;
            reads_left <= (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : count;
          end
        end
        RUN: begin
          if (issue) begin
            rd_ptr     <= rd_ptr + 1'b1;
            reads_left <= reads_left - 1'b1;
            if (reads_left == {{ADDR_W{1'b0}}, 1'b1}) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_hs) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the single read whose data arrives next cycle, tagging the burst's final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue && (reads_left == {{ADDR_W{1'b0}}, 1'b1});
    end
  end

  // Two-entry FIFO: capture returning ROM data, pop the head on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_idx   <= 1'b0;
      rd_idx   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (in_flight) begin
        fifo_data[wr_idx] <= rom_dout;
        fifo_last[wr_idx] <= in_flight_last;
        wr_idx            <= ~wr_idx;
      end
      if (hs) begin
        rd_idx <= ~rd_idx;
      end
      fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, hs};
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// tb/tb_rom_streamer.sv - scoreboard bench for rom_streamer
module tb_rom_streamer;
  localparam int DW = 20;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  rom_streamer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [64];
  always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  int busy_cycles = 0;
  int first_en_cyc = -1;
  int first_valid_cyc = -1;
  int done_cyc = -1;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_last_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_lastbit = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_lastbit, prev_data});
        if (done || prev_last_hs) chk("done_pulse", done, prev_last_hs);
        if (done) done_cyc = cyc;
        if (busy) busy_cycles++;
        if (rom_en) begin
          if (first_en_cyc < 0) first_en_cyc = cyc;
          if (addr_q.size() == 0) chk("unexpected_read", addr_q.size(), 1);
          else chk("rom_addr", rom_addr, addr_q.pop_front());
        end
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
          words_seen++;
          if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
          else chk("word", {m_last, m_data}, exp_q.pop_front());
        end
        prev_last_hs = m_valid && m_ready && m_last;
        prev_stall   = m_valid && !m_ready;
        prev_data    = m_data;
        prev_lastbit = m_last;
      end else begin
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
      end
    end
  end

  task automatic burst(input int addr, input int cnt, input bit rnd, input bit poke, input bit timing);
    int n;
    int t0;
    int k;
    n = (cnt == 0) ? 64 : cnt;
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(AW'((addr + i) % 64));
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, rom[(addr + i) % 64]});
    end
    first_en_cyc = -1;
    first_valid_cyc = -1;
    done_cyc = -1;
    busy_cycles = 0;
    rand_ready = rnd;
    if (!rnd) m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = AW'(addr);
    count = (AW+1)'(cnt);
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      start_addr = 6'd30;
      count = 7'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    k = 0;
    while (done_cyc < 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    chk("done_seen", (done_cyc >= 0), 1'b1);
    chk("words_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
    if (timing) begin
      chk("en_latency", first_en_cyc - t0, 1);
      chk("valid_latency", first_valid_cyc - t0, 3);
      chk("done_latency", done_cyc - t0, 3 + n);
      chk("busy_cycles", busy_cycles, n + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 64; i++) rom[i] = 20'(i * 'h1357 + 'h11);
    rom[0]  = 20'h0200A;
    rom[1]  = 20'h00300;
    rom[63] = 20'h0400D;

    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {rom_en, rom_addr, m_valid, m_data, m_last, busy, done}, '0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {m_valid, busy, rom_en}, 3'b000);

    burst(0, 2, 1'b0, 1'b0, 1'b1);
    burst(63, 3, 1'b0, 1'b0, 1'b1);
    burst(0, 0, 1'b0, 1'b0, 1'b1);
    burst(10, 8, 1'b1, 1'b0, 1'b0);
    burst(60, 8, 1'b1, 1'b0, 1'b0);
    burst(20, 6, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      addr_q.push_back(AW'(5 + i));
      exp_q.push_back({(i == 9) ? 1'b1 : 1'b0, rom[5 + i]});
    end
    k = words_seen;
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = 6'd5;
    count = 7'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int w = 0; w < 40 && words_seen < k + 3; w++) @(negedge clk);
    chk("third_word_seen", words_seen - k, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("reset_mid_burst", {rom_en, rom_addr, m_valid, m_data, m_last, busy, done}, '0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", {rom_en, m_valid, busy, done}, 4'b0000);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("quiet_after_reset", {rom_en, m_valid, busy}, 3'b000);
    burst(1, 1, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
